// File: rtl/seg8_pkg.sv
// rtl/seg8_pkg.sv - shared constants, hex segment table and FSM state type for the 8-digit scan controller
package seg8_pkg;

  // All segments (and dp) off for an active-low common-anode display
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex-to-segment table, active-low, bit order g..a; entry n lives at [n*7 +: 7]
  localparam logic [16*7-1:0] HEX_SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg8_state_e;

  // Index of the most significant nonzero nibble; 0 when the value is zero
  function automatic logic [2:0] hi_nibble(input logic [31:0] d);
    logic [2:0] hi;
    hi = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (d[k*4 +: 4] != 4'h0) hi = 3'(k);
    end
    return hi;
  endfunction

endpackage

// File: rtl/seg8_scan_ctrl_if.sv
// rtl/seg8_scan_ctrl_if.sv - valid/ready load port carrying the value, dp mask and blank mask
interface seg8_scan_ctrl_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic [7:0]  i_dp;
  logic [7:0]  i_blank;

  modport master (output i_valid, i_data, i_dp, i_blank, input o_ready);
  modport slave  (input i_valid, i_data, i_dp, i_blank, output o_ready);
endinterface

// File: rtl/seg8_hex_dec.sv
// rtl/seg8_hex_dec.sv - nibble plus decimal point to active-low segment byte
module seg8_hex_dec
  import seg8_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, HEX_SEG_TAB[int'(nib_i)*7 +: 7]};

endmodule

// File: rtl/seg8_scan_ctrl.sv
// rtl/seg8_scan_ctrl.sv - 8-digit multiplexed 7-segment scan controller; SEG8_LZB_EN enables leading-zero blanking
module seg8_scan_ctrl
  import seg8_pkg::*;
#(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  seg8_scan_ctrl_if.slave   ld,
  output logic              o_frame,
  output logic [7:0]        o_seg_com,
  output logic [7:0]        o_seg_d
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  seg8_state_e   state_q;
  logic [2:0]    dig_q;
  logic [CW-1:0] cnt_q;
  logic          go_q;
  logic          frame_q;
  logic [7:0]    com_q;
  logic [7:0]    seg_q;

  logic [31:0]   act_data_q;
  logic [7:0]    act_dp_q;
  logic [7:0]    act_blank_q;
  logic          pend_q;
  logic [31:0]   pend_data_q;
  logic [7:0]    pend_dp_q;
  logic [7:0]    pend_blank_q;

  logic [3:0]    nib;
  logic [7:0]    dec_seg;
  logic          lzb_dark;
  logic          dark;
  logic          blank_end;
  logic          drive_end;
  logic          commit;

  assign nib = act_data_q[{dig_q, 2'b00} +: 4];

  seg8_hex_dec u_dec (
    .nib_i (nib),
    .dp_i  (act_dp_q[dig_q]),
    .seg_o (dec_seg)
  );

`ifdef SEG8_LZB_EN
  // Digits above the top nonzero nibble go dark unless their dp is lit
  assign lzb_dark = (dig_q > hi_nibble(act_data_q)) & ~act_dp_q[dig_q];
`else
  assign lzb_dark = 1'b0;
`endif

  assign dark      = act_blank_q[dig_q] | lzb_dark;
  assign blank_end = go_q & (state_q == ST_BLANK) & (cnt_q == BLANK_LAST);
  assign drive_end = go_q & (state_q == ST_DRIVE) & (cnt_q == DWELL_LAST);
  // Swap in a new value only at the frame boundary so a frame never mixes two values
  assign commit    = drive_end & (dig_q == 3'd7) & pend_q;

  assign ld.o_ready = ~pend_q;
  assign o_frame    = frame_q;
  assign o_seg_com  = com_q;
  assign o_seg_d    = seg_q;

  // Pending slot: accept one load while empty, release it on commit
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q       <= 1'b0;
      pend_data_q  <= 32'h0;
      pend_dp_q    <= 8'h0;
      pend_blank_q <= 8'h0;
    end else if (commit) begin
      pend_q <= 1'b0;
    end else if (ld.i_valid && !pend_q) begin
      pend_q       <= 1'b1;
      pend_data_q  <= ld.i_data;
      pend_dp_q    <= ld.i_dp;
      pend_blank_q <= ld.i_blank;
    end
  end

  // Scan FSM with registered pin outputs and active-set update at frame end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_BLANK;
      dig_q       <= 3'd0;
      cnt_q       <= '0;
      go_q        <= 1'b0;
      frame_q     <= 1'b0;
      com_q       <= SEG_OFF;
      seg_q       <= SEG_OFF;
      act_data_q  <= 32'h0;
      act_dp_q    <= 8'h0;
      act_blank_q <= 8'h0;
    end else if (!go_q) begin
      // First edge after reset opens digit 0's blank phase and flags the frame
      go_q    <= 1'b1;
      frame_q <= 1'b1;
    end else if (blank_end) begin
      state_q <= ST_DRIVE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      com_q   <= dark ? SEG_OFF : ~(8'h01 << dig_q);
      seg_q   <= dark ? SEG_OFF : dec_seg;
    end else if (drive_end) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      dig_q   <= dig_q + 3'd1;
      frame_q <= (dig_q == 3'd7);
      com_q   <= SEG_OFF;
      seg_q   <= SEG_OFF;
      if (commit) begin
        act_data_q  <= pend_data_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
      end
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      frame_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg8_scan_ctrl.sv
// tb/tb_seg8_scan_ctrl.sv - directed self-checking bench for seg8_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2
module tb_seg8_scan_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       o_frame;
  logic [7:0] o_seg_com;
  logic [7:0] o_seg_d;
  int         passes = 0;
  int         fails = 0;
  int         total = 0;

  seg8_scan_ctrl_if ld ();

  seg8_scan_ctrl #(
    .DWELL_CYC (4),
    .BLANK_CYC (2)
  ) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .ld        (ld),
    .o_frame   (o_frame),
    .o_seg_com (o_seg_com),
    .o_seg_d   (o_seg_d)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " com"},   {24'h0, o_seg_com}, 32'hFF);
    chk({nm, " seg"},   {24'h0, o_seg_d},   32'hFF);
    chk({nm, " ready"}, {31'h0, ld.o_ready}, 32'h1);
    chk({nm, " frame"}, {31'h0, o_frame},   32'h0);
  endtask

  // Walks one 48-cycle frame starting at the o_frame cycle; eseg holds digit 7..0 segment bytes,
  // dark marks digits whose commons must stay off. Optional load, ignored re-offer and reset points.
  task automatic run_frame(input string nm, input logic [63:0] eseg, input logic [7:0] dark,
                           input int ld_off, input logic [31:0] ld_d, input logic [7:0] ld_dp,
                           input logic [7:0] ld_bl, input int ld2_off, input int rst_off);
    for (int o = 0; o < 48; o++) begin
      int         k;
      bit         drv;
      logic [7:0] ec;
      logic [7:0] es;
      k   = o / 6;
      drv = (o % 6) >= 2;
      ec  = (drv && !dark[k]) ? ~(8'h01 << k) : 8'hFF;
      es  = (drv && !dark[k]) ? eseg[k*8 +: 8] : 8'hFF;
      chk($sformatf("%s o%0d frame", nm, o), {31'h0, o_frame}, {31'h0, (o == 0)});
      chk($sformatf("%s o%0d com", nm, o), {24'h0, o_seg_com}, {24'h0, ec});
      chk($sformatf("%s o%0d seg", nm, o), {24'h0, o_seg_d}, {24'h0, es});
      if (o == 0) chk({nm, " ready_at_frame"}, {31'h0, ld.o_ready}, 32'h1);
      if (ld_off >= 0 && o == ld_off + 1) chk({nm, " ready_after_load"}, {31'h0, ld.o_ready}, 32'h0);
      if (o == rst_off) begin
        i_rstn = 1'b0;
        ld.i_valid = 1'b0;
        #1;
        chk_reset({nm, " async_rst"});
        tick();
        chk_reset({nm, " held_rst"});
        i_rstn = 1'b1;
        return;
      end
      if (o == ld_off) begin
        ld.i_valid = 1'b1;
        ld.i_data  = ld_d;
        ld.i_dp    = ld_dp;
        ld.i_blank = ld_bl;
      end else if (o == ld2_off) begin
        ld.i_valid = 1'b1;
        ld.i_data  = 32'hFFFF_FFFF;
        ld.i_dp    = 8'h00;
        ld.i_blank = 8'h00;
      end else begin
        ld.i_valid = 1'b0;
        ld.i_data  = 32'hDEAD_BEEF;
      end
      tick();
    end
  endtask

  localparam logic [63:0] SEG_ZERO = 64'hC0C0_C0C0_C0C0_C0C0;
  localparam logic [63:0] SEG_1234 = 64'hF9A4_B099_8883_C621;
  localparam logic [63:0] SEG_ALLF = 64'h8E8E_8E8E_8E8E_8E8E;
  localparam logic [63:0] SEG_A5   = 64'hFFFF_FFFF_C0C0_8892;
`ifdef SEG8_LZB_EN
  localparam logic [7:0]  DARK_A5   = 8'hFC;
  localparam logic [7:0]  DARK_ZERO = 8'hFE;
`else
  localparam logic [7:0]  DARK_A5   = 8'hF0;
  localparam logic [7:0]  DARK_ZERO = 8'h00;
`endif

  initial begin
    ld.i_valid = 1'b0;
    ld.i_data  = 32'h0;
    ld.i_dp    = 8'h0;
    ld.i_blank = 8'h0;
    i_rstn     = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    i_rstn = 1'b1;
    tick();
    run_frame("f1_zero", SEG_ZERO, 8'h00, 8, 32'h1234_ABCD, 8'h01, 8'h00, 20, -1);
    run_frame("f2_1234", SEG_1234, 8'h00, 4, 32'hFFFF_FFFF, 8'h00, 8'h00, -1, -1);
    run_frame("f3_allF", SEG_ALLF, 8'h00, 4, 32'h0000_00A5, 8'h00, 8'hF0, -1, -1);
    run_frame("f4_A5",   SEG_A5,   DARK_A5, 4, 32'h0000_0000, 8'h00, 8'h00, -1, -1);
    run_frame("f5_zero", SEG_ZERO, DARK_ZERO, 4, 32'h5555_5555, 8'h00, 8'h00, -1, 21);
    tick();
    run_frame("f6_post_rst", SEG_ZERO, 8'h00, -1, 32'h0, 8'h00, 8'h00, -1, -1);
    run_frame("f7_zero", SEG_ZERO, 8'h00, -1, 32'h0, 8'h00, 8'h00, -1, -1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
